// File: rtl/uart_rx_pkg.sv
// uart_rx_pkg: shared frame constants and receiver state encoding
package uart_rx_pkg;
  localparam int DATA_BITS    = 8;
  localparam int OVERSAMPLE   = 16;
  localparam int TICK_CNT_BIT = 4;
  localparam int BIT_CNT_BIT  = 3;
  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    START = 3'd1,
    DATA  = 3'd2,
    STOP  = 3'd3,
    BREAK = 3'd4
  } state_t;
endpackage

// File: rtl/uart_rx_edge_sync.sv
// uart_edge_sync: 2-flop synchroniser with a previous-value flop for rising-edge detect
module uart_edge_sync #(
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic rise
);
  logic [2:0] s;
  always_ff @(posedge clk or negedge reset)
    if (!reset) s <= {3{RST_VAL}};
    else s <= {s[1:0], d};
  assign rise = s[1] & ~s[2];
endmodule

// File: rtl/uart_rx.sv
// uart_rx: 8N1 receive engine driven by the x16 oversample tick
module uart_rx #(
  parameter int DATA_BITS    = uart_rx_pkg::DATA_BITS,
  parameter int OVERSAMPLE   = uart_rx_pkg::OVERSAMPLE,
  parameter int TICK_CNT_BIT = uart_rx_pkg::TICK_CNT_BIT,
  parameter int BIT_CNT_BIT  = uart_rx_pkg::BIT_CNT_BIT
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 i_X16_Sample_Clk,
  input  logic                 i_Rx,
  output logic [DATA_BITS-1:0] o_Rx_Data,
  output logic                 o_Rx_Valid,
  output logic                 o_Frame_Err,
  output logic                 o_Busy
);
  import uart_rx_pkg::*;
  localparam logic [TICK_CNT_BIT-1:0] T_HALF = TICK_CNT_BIT'(OVERSAMPLE/2 - 1);
  localparam logic [TICK_CNT_BIT-1:0] T_END  = TICK_CNT_BIT'(OVERSAMPLE - 1);
  localparam logic [BIT_CNT_BIT-1:0]  B_END  = BIT_CNT_BIT'(DATA_BITS - 1);
  state_t state, state_n;
  logic [TICK_CNT_BIT-1:0] tick_cnt, tick_n;
  logic [BIT_CNT_BIT-1:0] bit_cnt, bit_n;
  logic [DATA_BITS-1:0] shreg, sh_n, data_n;
  logic [1:0] rx_q;
  logic rx_s, tick, valid_n, ferr_n;
  uart_edge_sync #(.RST_VAL(1'b0)) u_tick (
    .clk(clk), .reset(reset), .d(i_X16_Sample_Clk), .rise(tick)
  );
  always_ff @(posedge clk or negedge reset)
    if (!reset) rx_q <= 2'b11;
    else rx_q <= {rx_q[0], i_Rx};
  assign rx_s = rx_q[1];
  assign o_Busy = state != IDLE;
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      state       <= IDLE;
      tick_cnt    <= '0;
      bit_cnt     <= '0;
      shreg       <= '0;
      o_Rx_Data   <= '0;
      o_Rx_Valid  <= 1'b0;
      o_Frame_Err <= 1'b0;
    end else begin
      state       <= state_n;
      tick_cnt    <= tick_n;
      bit_cnt     <= bit_n;
      shreg       <= sh_n;
      o_Rx_Data   <= data_n;
      o_Rx_Valid  <= valid_n;
      o_Frame_Err <= ferr_n;
    end
  always_comb begin
    state_n = state;
    tick_n  = tick_cnt;
    bit_n   = bit_cnt;
    sh_n    = shreg;
    data_n  = o_Rx_Data;
    valid_n = 1'b0;
    ferr_n  = 1'b0;
    if (tick)
      case (state)
        IDLE: if (!rx_s) begin
          state_n = START;
          tick_n  = '0;
        end
        START: if (tick_cnt == T_HALF) begin
          state_n = rx_s ? IDLE : DATA;
          tick_n  = '0;
          bit_n   = '0;
        end else tick_n = tick_cnt + 1'b1;
        DATA: if (tick_cnt == T_END) begin
          sh_n    = {rx_s, shreg[DATA_BITS-1:1]};
          tick_n  = '0;
          state_n = bit_cnt == B_END ? STOP : DATA;
          bit_n   = bit_cnt == B_END ? bit_cnt : bit_cnt + 1'b1;
        end else tick_n = tick_cnt + 1'b1;
        STOP: if (tick_cnt == T_END) begin
          tick_n  = '0;
          state_n = rx_s ? IDLE : BREAK;
          data_n  = rx_s ? shreg : o_Rx_Data;
          valid_n = rx_s;
          ferr_n  = !rx_s;
        end else tick_n = tick_cnt + 1'b1;
        BREAK: if (rx_s) state_n = IDLE;
        default: state_n = IDLE;
      endcase
  end
endmodule
